freq_meter_mc: RTL
==================

# freq_meter_mc

Multi-channel gated frequency meter core for the Nios display system. It counts rising edges on up to CHANNELS asynchronous inputs over a programmable gate window of clk_clk cycles. It snapshots the counts at gate end and streams one result per channel through a valid/ready port for the PIO/Avalon bridge to read. It generalises the single 32-bit freq/freq_en pair to N channels, configurable widths, continuous re-triggering and double-buffered readout.

## Interface
- CHANNELS, 4: number of measured inputs, 1..16
- CNT_W, 32: edge counter and result width
- GATE_W, 32: gate length register width
- SYNC_STAGES, 2: synchroniser depth on each sig_in bit, at least 2
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- sig_in  in  CHANNELS  asynchronous signals under measurement
- gate_cycles  in  GATE_W  gate length in clk_clk cycles; latched at gate start; 0 is treated as 1
- start  in  1  single-cycle request to begin a measurement
- continuous  in  1  when high, a new gate starts immediately after each gate ends
- busy  out  1  high while a gate is open
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_chan  out  $clog2(CHANNELS) (min 1)  channel index of the current result
- res_count  out  CNT_W  edges counted in the gate
- res_ovf  out  1  counter saturated during the gate
- time_del  out  GATE_W  gate length actually used for the current snapshot
- overrun  out  1  sticky; a snapshot was dropped; cleared by start

## Operation
- Each sig_in bit passes through a SYNC_STAGES flip-flop synchroniser, then a rising-edge detector (sync_q & ~sync_q_d).
- Gate FSM states:
  - IDLE: on start=1, go to ARM.
  - ARM: one cycle. Clear the counters, latch G = max(gate_cycles, 1), load gate_cnt = G-1. Next state is GATE.
  - GATE: lasts exactly G cycles. Each detected edge increments its channel counter. At gate_cnt=0, take a snapshot, then go to ARM if continuous=1, else IDLE.
- Snapshot: all counts, ovf flags and G copy into a shadow bank, and the drain pointer resets to 0.
  - If the previous bank is not fully drained at snapshot time, the new snapshot is dropped and overrun is set. The old bank keeps draining.
- Drain: runs independently of the gate FSM. Presents channels 0..CHANNELS-1 in order, then res_valid drops.
- Handshake:
  - A transfer occurs when res_valid & res_ready.
  - res_chan, res_count, res_ovf and time_del stay stable while res_valid=1 and res_ready=0.
  - res_valid never drops without a transfer, except on reset.
- start while busy=1 or while in ARM is ignored. Deasserting continuous during GATE finishes the current gate, then the FSM returns to IDLE.
- Arithmetic: counters are CNT_W unsigned. An edge and the snapshot in the same cycle: the edge is included in the snapshot.

## Timing
- All outputs reset to 0; FSM resets to IDLE; shadow bank is empty.
- Input edge to counter increment: SYNC_STAGES+1 cycles.
- start to busy=1: 2 cycles (IDLE→ARM→GATE).
- Last GATE cycle to res_valid=1 for channel 0: 1 cycle.
- Drain takes at least CHANNELS cycles with res_ready held high.
- Continuous mode has no dead cycle except ARM, so the gate period is G+1 cycles.
- Reset mid-gate or mid-drain aborts immediately, with no partial result emitted.

## Configuration
- FREQ_METER_SAT_EN defined:
  - Counters saturate at 2^CNT_W-1.
  - res_ovf reports the sticky per-gate saturation.
- Not defined:
  - Counters wrap modulo 2^CNT_W.
  - res_ovf is tied to 0.

## Structure
- Package freq_meter_pkg holds:
  - the FSM state enum (IDLE, ARM, GATE)
  - the chan_idx width function
  - the result struct {chan, count, ovf}
- One sub-module, freq_meter_edge_sync: per-bit synchroniser plus rising-edge detector, instantiated CHANNELS times.

## Test plan
- Single measurement: gate_cycles=100, sig_in[0] toggling with period 10 (10 rising edges in the window), other channels idle, start pulse.
  - Expected: results in order ch0=10, ch1=0, ch2=0, ch3=0; time_del=100.
- gate_cycles=0:
  - Expected: gate lasts 1 cycle; time_del=1.
- Backpressure: res_ready low for 20 cycles after res_valid.
  - Expected: outputs stable; then 4 consecutive transfers with ready high.
- Continuous with res_ready=0, gate_cycles=8:
  - Expected: second snapshot dropped; overrun=1; first bank still delivered intact; next start clears overrun.
- Saturation: CNT_W=4, 20 edges in the gate.
  - With FREQ_METER_SAT_EN: count=15, ovf=1.
  - Without: count=4, ovf=0.
- reset_reset pulsed mid-GATE and mid-drain:
  - Expected: res_valid=0 and busy=0 the next cycle; the next start produces a clean result.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types for the multi-channel frequency meter: gate FSM states, channel index width
// and the result record presented on the readout port (sized for up to 16 channels / 64-bit counts).
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } gate_state_t;

  localparam int MAX_CHAN_W = 4;
  localparam int MAX_CNT_W  = 64;

  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  typedef struct packed {
    logic [MAX_CHAN_W-1:0] chan;
    logic [MAX_CNT_W-1:0]  count;
    logic                  ovf;
  } result_t;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Brings one asynchronous input into the clock domain and emits a one-cycle pulse per rising edge.
module freq_meter_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_d_r;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r   <= '0;
      sync_d_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], sig};
      sync_d_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~sync_d_r;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel gated frequency meter with a shadow bank drained over a valid/ready port.
// Define FREQ_METER_SAT_EN for saturating counters with overflow reporting; otherwise counters wrap.
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic [CHANNELS-1:0]           sig_in,
  input  logic [GATE_W-1:0]             gate_cycles,
  input  logic                          start,
  input  logic                          continuous,
  output logic                          busy,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [chan_w(CHANNELS)-1:0]   res_chan,
  output logic [CNT_W-1:0]              res_count,
  output logic                          res_ovf,
  output logic [GATE_W-1:0]             time_del,
  output logic                          overrun
);

  localparam int                CW        = chan_w(CHANNELS);
  localparam logic [CW-1:0]     LAST_CHAN = CW'(CHANNELS - 1);
  localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1'b1);
  localparam logic [GATE_W-1:0] ONE_G     = GATE_W'(1'b1);

  gate_state_t          state_r, state_next_s;
  logic [CHANNELS-1:0]  rise_s;
  logic [CNT_W-1:0]     cnt_r        [CHANNELS];
  logic [CNT_W-1:0]     cnt_next_s   [CHANNELS];
  logic [CNT_W-1:0]     shadow_cnt_r [CHANNELS];
  logic [CHANNELS-1:0]  ovf_r, ovf_next_s, shadow_ovf_r;
  logic [GATE_W-1:0]    gate_len_r, gate_cnt_r, gate_len_s, time_del_r;
  logic [CW-1:0]        next_chan_s;
  result_t              res_r;
  logic                 res_valid_r, busy_r, overrun_r;
  logic                 gate_end_s, drained_s, take_s, drop_s;
  logic                 unused_bits_s;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    freq_meter_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .sig  (sig_in[g]),
      .rise (rise_s[g])
    );
  end

  assign gate_len_s  = (gate_cycles == '0) ? ONE_G : gate_cycles;
  assign gate_end_s  = (state_r == GATE) && (gate_cnt_r == '0);
  // A bank whose final channel transfers this very cycle counts as drained.
  assign drained_s   = !res_valid_r || (res_ready && (res_r.chan[CW-1:0] == LAST_CHAN));
  assign take_s      = gate_end_s && drained_s;
  assign drop_s      = gate_end_s && !drained_s;
  assign next_chan_s = res_r.chan[CW-1:0] + CW'(1'b1);

  // Gate FSM next-state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = ARM;
        else       state_next_s = IDLE;
      end
      ARM:  state_next_s = GATE;
      GATE: begin
        if (gate_cnt_r == '0) state_next_s = continuous ? ARM : IDLE;
        else                  state_next_s = GATE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Next counter values including an edge coincident with the snapshot
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_next_s[i] = cnt_r[i];
      ovf_next_s[i] = ovf_r[i];
      if ((state_r == GATE) && rise_s[i]) begin
`ifdef FREQ_METER_SAT_EN
        if (&cnt_r[i]) ovf_next_s[i] = 1'b1;
        else           cnt_next_s[i] = cnt_r[i] + ONE_CNT;
`else
        cnt_next_s[i] = cnt_r[i] + ONE_CNT;
`endif
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Gate FSM state, gate length latch and remaining-cycle counter
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      gate_len_r <= '0;
      gate_cnt_r <= '0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == GATE);
      if (state_r == ARM) begin
        gate_len_r <= gate_len_s;
        gate_cnt_r <= gate_len_s - ONE_G;
      end else if ((state_r == GATE) && (gate_cnt_r != '0)) begin
        gate_cnt_r <= gate_cnt_r - ONE_G;
      end
    end
  end

  // Per-channel edge counters, cleared while arming
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < CHANNELS; i++) cnt_r[i] <= '0;
      ovf_r <= '0;
    end else if (state_r == ARM) begin
      for (int i = 0; i < CHANNELS; i++) cnt_r[i] <= '0;
      ovf_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_r[i] <= cnt_next_s[i];
      ovf_r <= ovf_next_s;
    end
  end

  // Snapshot into the shadow bank and drain it one channel per transfer
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < CHANNELS; i++) shadow_cnt_r[i] <= '0;
      shadow_ovf_r <= '0;
      res_r        <= '0;
      res_valid_r  <= 1'b0;
      time_del_r   <= '0;
    end else if (take_s) begin
      for (int i = 0; i < CHANNELS; i++) shadow_cnt_r[i] <= cnt_next_s[i];
      shadow_ovf_r <= ovf_next_s;
      res_r.chan   <= '0;
      res_r.count  <= MAX_CNT_W'(cnt_next_s[0]);
      res_r.ovf    <= ovf_next_s[0];
      res_valid_r  <= 1'b1;
      time_del_r   <= gate_len_r;
    end else if (res_valid_r && res_ready) begin
      if (res_r.chan[CW-1:0] == LAST_CHAN) begin
        res_valid_r <= 1'b0;
      end else begin
        res_r.chan  <= MAX_CHAN_W'(next_chan_s);
        res_r.count <= MAX_CNT_W'(shadow_cnt_r[next_chan_s]);
        res_r.ovf   <= shadow_ovf_r[next_chan_s];
      end
    end
  end

  // Sticky overrun: set by a dropped snapshot, cleared by an accepted start
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      overrun_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end
  end

  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign res_chan  = res_r.chan[CW-1:0];
  assign res_count = res_r.count[CNT_W-1:0];
  assign time_del  = time_del_r;
  assign overrun   = overrun_r;
`ifdef FREQ_METER_SAT_EN
  assign res_ovf   = res_r.ovf;
`else
  assign res_ovf   = 1'b0;
`endif
  assign unused_bits_s = ^{res_r.count, res_r.chan, res_r.ovf};

endmodule
